// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: request/response bundle joining the IF and D
// requesters and the memory port to mem_port_arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req_valid;
    logic [ADDR_W-1:0] if_req_addr;
    logic              if_req_ready;
    logic              if_rsp_valid;
    logic [DATA_W-1:0] if_rsp_data;
    logic              if_rsp_err;

    logic                d_req_valid;
    logic [ADDR_W-1:0]   d_req_addr;
    logic                d_req_we;
    logic [DATA_W-1:0]   d_req_wdata;
    logic [DATA_W/8-1:0] d_req_wstrb;
    logic                d_req_ready;
    logic                d_rsp_valid;
    logic [DATA_W-1:0]   d_rsp_rdata;
    logic                d_rsp_err;

    logic                mem_req_valid;
    logic                mem_req_ready;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_we;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W/8-1:0] mem_wstrb;
    logic                mem_rsp_valid;
    logic [DATA_W-1:0]   mem_rsp_rdata;

    modport master (
        output if_req_valid, if_req_addr,
        output d_req_valid, d_req_addr, d_req_we,
        output d_req_wdata, d_req_wstrb,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
        input  d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err,
        input  mem_req_valid, mem_addr, mem_we, mem_wdata, mem_wstrb
    );

    modport slave (
        input  if_req_valid, if_req_addr,
        input  d_req_valid, d_req_addr, d_req_we,
        input  d_req_wdata, d_req_wstrb,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
        output d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err,
        output mem_req_valid, mem_addr, mem_we, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch (IF) and load/store (D).
// Define ARB_ROUND_ROBIN_EN to alternate grants on ties instead of D-first.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    mem_port_arbiter_if.slave  bus,
    output logic               busy,
    output logic               owner
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_t;

    state_t state, state_nx;

    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic              owner_q;
    logic [TO_W-1:0]   cnt_q;

    logic              if_rsp_v_q, if_rsp_err_q;
    logic [DATA_W-1:0] if_rsp_data_q;
    logic              d_rsp_v_q, d_rsp_err_q;
    logic [DATA_W-1:0] d_rsp_data_q;

    logic              gnt_if, gnt_d, hs, sel_mis, timeout;
    logic              fire, fire_err;
    logic [DATA_W-1:0] fire_data;

    assign hs      = gnt_if | gnt_d;
    assign sel_mis = gnt_d ? (bus.d_req_addr[1:0] != 2'b00)
                           : (bus.if_req_addr[1:0] != 2'b00);
    assign timeout = (cnt_q == TO_W'(TIMEOUT - 1));

    // Pick the requester to accept while idle.
    always_comb begin
        gnt_d  = 1'b0;
        gnt_if = 1'b0;
        if (state == IDLE) begin
`ifdef ARB_ROUND_ROBIN_EN
            gnt_d = bus.d_req_valid && (!bus.if_req_valid || !owner_q);
`else
            gnt_d = bus.d_req_valid;
`endif
            gnt_if = bus.if_req_valid && !gnt_d;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (hs) state_nx = sel_mis ? ERR : REQ;
            REQ:  if (bus.mem_req_ready) state_nx = RESP;
            RESP: if (bus.mem_rsp_valid || timeout) state_nx = IDLE;
            ERR:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Handshake/status outputs and the response about to be issued.
    always_comb begin
        bus.if_req_ready  = gnt_if;
        bus.d_req_ready   = gnt_d;
        bus.mem_req_valid = (state == REQ);
        busy              = (state != IDLE);
        fire              = 1'b0;
        fire_err          = 1'b0;
        fire_data         = '0;
        unique case (state)
            RESP: begin
                if (bus.mem_rsp_valid) begin
                    fire      = 1'b1;
                    fire_data = we_q ? '0 : bus.mem_rsp_rdata;
                end else if (timeout) begin
                    fire     = 1'b1;
                    fire_err = 1'b1;
                end
            end
            ERR: begin
                fire     = 1'b1;
                fire_err = 1'b1;
            end
            default: ;
        endcase
    end

    // Latch the accepted request, run the timeout counter, register responses.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr_q        <= '0;
            we_q          <= 1'b0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            owner_q       <= 1'b1;
            cnt_q         <= '0;
            if_rsp_v_q    <= 1'b0;
            if_rsp_err_q  <= 1'b0;
            if_rsp_data_q <= '0;
            d_rsp_v_q     <= 1'b0;
            d_rsp_err_q   <= 1'b0;
            d_rsp_data_q  <= '0;
        end else begin
            if_rsp_v_q    <= 1'b0;
            if_rsp_err_q  <= 1'b0;
            if_rsp_data_q <= '0;
            d_rsp_v_q     <= 1'b0;
            d_rsp_err_q   <= 1'b0;
            d_rsp_data_q  <= '0;
            if (hs) begin
                owner_q <= gnt_d;
                if (gnt_d) begin
                    addr_q  <= bus.d_req_addr;
                    we_q    <= bus.d_req_we;
                    wdata_q <= bus.d_req_wdata;
                    wstrb_q <= bus.d_req_wstrb;
                end else begin
                    addr_q  <= bus.if_req_addr;
                    we_q    <= 1'b0;
                    wdata_q <= '0;
                    wstrb_q <= '0;
                end
            end
            if (state == REQ && bus.mem_req_ready) cnt_q <= '0;
            if (state == RESP) cnt_q <= cnt_q + TO_W'(1);
            if (fire) begin
                if (owner_q) begin
                    d_rsp_v_q    <= 1'b1;
                    d_rsp_err_q  <= fire_err;
                    d_rsp_data_q <= fire_data;
                end else begin
                    if_rsp_v_q    <= 1'b1;
                    if_rsp_err_q  <= fire_err;
                    if_rsp_data_q <= fire_data;
                end
            end
        end
    end

    assign owner           = owner_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_we      = we_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.mem_wstrb   = wstrb_q;
    assign bus.if_rsp_valid = if_rsp_v_q;
    assign bus.if_rsp_err   = if_rsp_err_q;
    assign bus.if_rsp_data  = if_rsp_data_q;
    assign bus.d_rsp_valid  = d_rsp_v_q;
    assign bus.d_rsp_err    = d_rsp_err_q;
    assign bus.d_rsp_rdata  = d_rsp_data_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed table, corner sequences and random traffic
// for mem_port_arbiter built with TIMEOUT=4.
module tb_mem_port_arbiter;
    localparam int TO = 4;

    typedef struct {
        bit          own;
        logic [31:0] addr;
        bit          we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          r;
        int          d;
        bit          spur;
        logic [31:0] rdata;
        int          lat;
        logic [31:0] data;
        bit          err;
    } txn_t;

    logic clk = 1'b0;
    logic reset_n;
    logic busy, owner;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT(TO), .TO_W(8)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus),
        .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bit          p_if, p_d, we_d, last_own;
    logic [31:0] a_if, a_d, wd_d, g_rdata;
    logic [3:0]  st_d;
    bit          g_mrdy, g_mrsp, g_rst;

    task automatic chk(input string nm, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        reset_n               = g_rst;
        bus.if_req_valid      = p_if;
        bus.if_req_addr       = a_if;
        bus.d_req_valid       = p_d;
        bus.d_req_addr        = a_d;
        bus.d_req_we          = we_d;
        bus.d_req_wdata       = wd_d;
        bus.d_req_wstrb       = st_d;
        bus.mem_req_ready     = g_mrdy;
        bus.mem_rsp_valid     = g_mrsp;
        bus.mem_rsp_rdata     = g_rdata;
        #1;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_ctl"},
            128'({busy, owner, bus.if_req_ready, bus.d_req_ready,
                  bus.if_rsp_valid, bus.if_rsp_err, bus.d_rsp_valid,
                  bus.d_rsp_err, bus.mem_req_valid, bus.mem_we,
                  bus.mem_wstrb}),
            128'(14'b01_0000_0000_0000));
        chk({nm, "_dat"},
            {bus.mem_addr, bus.mem_wdata, bus.if_rsp_data, bus.d_rsp_rdata},
            128'd0);
    endtask

    task automatic do_reset();
        p_if = 0; p_d = 0; g_mrdy = 0; g_mrsp = 0; g_rst = 0;
        step();
        step();
        g_rst = 1;
        step();
        last_own = 1;
        chk_zero("reset");
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        a = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(7) == 0) a[1:0] = 2'($urandom_range(3, 1));
        return a;
    endfunction

    task automatic new_if();
        p_if = 1;
        a_if = rnd_addr();
    endtask

    task automatic new_d();
        p_d  = 1;
        a_d  = rnd_addr();
        we_d = 1'($urandom_range(1));
        wd_d = $urandom;
        st_d = 4'($urandom_range(15));
    endtask

    // Runs one transaction from its handshake cycle to its response.
    // mode 0: no new requests, 1: random new requests, 2: winner re-requests.
    task automatic txn(input txn_t t, input bit fresh, input int mode);
        bit mis;
        mis = (t.addr[1:0] != 2'b00);
        g_rdata = t.rdata;
        if (fresh) step();
        chk("grant", 128'({bus.if_req_ready, bus.d_req_ready}),
            128'(t.own ? 2'b01 : 2'b10));
        if (t.own) p_d = 0;
        else       p_if = 0;
        last_own = t.own;
        for (int k = 1; k <= t.lat; k++) begin
            g_mrdy = !mis && (k == 1 + t.r);
            g_mrsp = (t.spur && k == 1) ||
                     (!mis && t.d < TO && k == 2 + t.r + t.d);
            if (mode == 1) begin
                if (!p_if && $urandom_range(3) == 0) new_if();
                if (!p_d && $urandom_range(3) == 0) new_d();
            end
            if (mode == 2 && k == 1) begin
                if (t.own) begin
                    p_d = 1; a_d = 32'h504; we_d = 0;
                end else begin
                    p_if = 1; a_if = 32'h404;
                end
            end
            step();
            chk("mreq_v", 128'(bus.mem_req_valid),
                128'(!mis && k <= 1 + t.r));
            if (k == 1) chk("owner", 128'(owner), 128'(t.own));
            if (!mis && k <= 1 + t.r) begin
                chk("mfields", 128'({bus.mem_addr, bus.mem_we, bus.mem_wstrb}),
                    128'({t.addr, t.we, t.wstrb}));
                if (t.own) chk("mwdata", 128'(bus.mem_wdata), 128'(t.wdata));
            end
            if (k < t.lat) begin
                chk("busy_rsp", 128'({busy, bus.if_rsp_valid, bus.d_rsp_valid,
                                      bus.if_req_ready, bus.d_req_ready}),
                    128'(5'b10000));
            end else begin
                chk("rsp_v", 128'({busy, bus.if_rsp_valid, bus.d_rsp_valid}),
                    128'(t.own ? 3'b001 : 3'b010));
                if (t.own)
                    chk("d_rsp", 128'({bus.d_rsp_rdata, bus.d_rsp_err}),
                        128'({t.data, t.err}));
                else
                    chk("if_rsp", 128'({bus.if_rsp_data, bus.if_rsp_err}),
                        128'({t.data, t.err}));
            end
        end
        g_mrdy = 0;
        g_mrsp = 0;
    endtask

    function automatic txn_t mk(input bit own, input logic [31:0] addr,
                                input bit we, input logic [31:0] wdata,
                                input logic [3:0] wstrb, input int r,
                                input int d, input bit spur,
                                input logic [31:0] rdata, input int lat,
                                input logic [31:0] data, input bit err);
        txn_t t;
        t.own = own; t.addr = addr; t.we = we; t.wdata = wdata;
        t.wstrb = wstrb; t.r = r; t.d = d; t.spur = spur;
        t.rdata = rdata; t.lat = lat; t.data = data; t.err = err;
        return t;
    endfunction

    // Expected outcome from the arbitration rule and the latency arithmetic.
    function automatic txn_t model_next();
        txn_t t;
        bit   mis;
`ifdef ARB_ROUND_ROBIN_EN
        t.own = p_d && (!p_if || last_own == 1'b0);
`else
        t.own = p_d;
`endif
        t.addr  = t.own ? a_d : a_if;
        t.we    = t.own ? we_d : 1'b0;
        t.wdata = t.own ? wd_d : 32'h0;
        t.wstrb = t.own ? st_d : 4'h0;
        t.r     = $urandom_range(3);
        t.d     = $urandom_range(5);
        t.spur  = 1'($urandom_range(1));
        t.rdata = $urandom;
        mis     = (t.addr[1:0] != 2'b00);
        t.err   = mis || t.d >= TO;
        t.lat   = mis ? 2 : 3 + t.r + ((t.d < TO) ? t.d : TO - 1);
        t.data  = (t.err || t.we) ? 32'h0 : t.rdata;
        return t;
    endfunction

    txn_t tab[8];

    initial begin
        txn_t t;
        bit   fresh;

        tab[0] = mk(0, 32'h10,  0, 0, 0,     0, 0, 0, 32'h0010_0093,
                    3, 32'h0010_0093, 0);
        tab[1] = mk(1, 32'h100, 1, 32'hDEAD_BEEF, 4'hF, 3, 0, 0,
                    32'h1234_5678, 6, 32'h0, 0);
        tab[2] = mk(1, 32'h102, 0, 0, 0,     0, 0, 0, 32'h5555_5555,
                    2, 32'h0, 1);
        tab[3] = mk(0, 32'h20,  0, 0, 0,     0, 9, 0, 32'h7777_7777,
                    6, 32'h0, 1);
        tab[4] = mk(1, 32'h200, 0, 0, 0,     1, 2, 0, 32'hCAFE_F00D,
                    6, 32'hCAFE_F00D, 0);
        tab[5] = mk(1, 32'h204, 0, 0, 0,     0, 3, 0, 32'hA5A5_A5A5,
                    6, 32'hA5A5_A5A5, 0);
        tab[6] = mk(0, 32'h31,  0, 0, 0,     0, 0, 1, 32'h9999_9999,
                    2, 32'h0, 1);
        tab[7] = mk(1, 32'h300, 1, 32'h0BAD_F00D, 4'h3, 2, 1, 1,
                    32'h4444_4444, 6, 32'h0, 0);

        reset_n = 0;
        p_if = 0; p_d = 0; a_if = 0; a_d = 0; we_d = 0; wd_d = 0; st_d = 0;
        g_rdata = 0; g_mrdy = 0; g_mrsp = 0; g_rst = 0;
        bus.if_req_valid = 0; bus.if_req_addr = 0;
        bus.d_req_valid = 0; bus.d_req_addr = 0; bus.d_req_we = 0;
        bus.d_req_wdata = 0; bus.d_req_wstrb = 0;
        bus.mem_req_ready = 0; bus.mem_rsp_valid = 0; bus.mem_rsp_rdata = 0;

        do_reset();

        for (int i = 0; i < 8; i++) begin
            if (tab[i].own) begin
                p_d = 1; a_d = tab[i].addr; we_d = tab[i].we;
                wd_d = tab[i].wdata; st_d = tab[i].wstrb;
            end else begin
                p_if = 1; a_if = tab[i].addr;
            end
            txn(tab[i], 1, 0);
        end

        // Timeout, then a late memory response that must be dropped.
        p_if = 1; a_if = 32'h40;
        txn(mk(0, 32'h40, 0, 0, 0, 0, 9, 0, 32'h1, 6, 32'h0, 1), 1, 0);
        g_mrsp = 1;
        step();
        g_mrsp = 0;
        step();
        chk("late_rsp", 128'({bus.if_rsp_valid, bus.d_rsp_valid, busy}),
            128'(3'b000));

        // Both requesters valid for two back-to-back grants.
        do_reset();
        p_if = 1; a_if = 32'h400;
        p_d = 1; a_d = 32'h500; we_d = 0; wd_d = 0; st_d = 0;
`ifdef ARB_ROUND_ROBIN_EN
        txn(mk(0, 32'h400, 0, 0, 0, 0, 0, 0, 32'hAAAA_0001,
               3, 32'hAAAA_0001, 0), 1, 2);
        txn(mk(1, 32'h500, 0, 0, 0, 0, 0, 0, 32'hAAAA_0002,
               3, 32'hAAAA_0002, 0), 0, 0);
`else
        txn(mk(1, 32'h500, 0, 0, 0, 0, 0, 0, 32'hAAAA_0001,
               3, 32'hAAAA_0001, 0), 1, 2);
        txn(mk(1, 32'h504, 0, 0, 0, 0, 0, 0, 32'hAAAA_0002,
               3, 32'hAAAA_0002, 0), 0, 0);
`endif

        // Reset while waiting in RESP; the stale response is ignored.
        do_reset();
        p_if = 1; a_if = 32'h60; g_rdata = 32'h1111_2222;
        step();
        chk("rr_grant", 128'({bus.if_req_ready, bus.d_req_ready}),
            128'(2'b10));
        p_if = 0;
        g_mrdy = 1;
        step();
        g_mrdy = 0;
        g_rst = 0;
        step();
        chk("rr_busy", 128'(busy), 128'(1));
        g_rst = 1;
        g_mrsp = 1;
        step();
        last_own = 1;
        chk_zero("rr_after");
        g_mrsp = 0;
        step();
        chk("rr_ignored", 128'({bus.if_rsp_valid, bus.d_rsp_valid, busy}),
            128'(3'b000));
        p_if = 1; a_if = 32'h80;
        txn(mk(0, 32'h80, 0, 0, 0, 0, 1, 0, 32'h00A0_0513,
               4, 32'h00A0_0513, 0), 1, 0);

        // Random traffic against the transaction-level model.
        do_reset();
        for (int n = 0; n < 80; n++) begin
            fresh = 0;
            if (!p_if && !p_d) begin
                fresh = 1;
                case ($urandom_range(2))
                    0: new_if();
                    1: new_d();
                    default: begin new_if(); new_d(); end
                endcase
            end
            t = model_next();
            txn(t, fresh, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
